axi_xdma_st_data_chk_yuri_slave_stream: RTL and testbench

AXI-Stream slave that terminates the XDMA H2C stream and checks it against the counter pattern the data generator emits. It applies the same start value, step and direction rules, checks TLAST placement and TSTRB, and reports error, beat and packet counts to the register bank. It pairs with the generator for loopback and throughput tests and can optionally throttle TREADY to exercise backpressure.

---
 rtl/axi_xdma_st_yuri_pkg.sv | 29 ++
 rtl/axi_xdma_st_yuri_pattern_next.sv | 22 ++
 rtl/axi_xdma_st_data_chk_yuri_slave_stream.sv | 160 ++++++++++++++++
 tb/tb_axi_xdma_st_data_chk_yuri_slave_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xdma_st_yuri_pkg.sv
// Purpose : shared definitions for the XDMA stream counter-pattern generator and checker.
// Latency : n/a (package only).
// Backpressure: n/a. Contents: FSM state encoding, config_reg0 bit indices, status bit indices, step helper.
package axi_xdma_st_yuri_pkg;

    // Checker FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEED = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // config_reg0 bit positions, common to generator and checker
    localparam int CFG_HOLD     = 0;
    localparam int CFG_DOWN     = 1;
    localparam int CFG_CLEAR    = 2;
    localparam int CFG_THROTTLE = 3;
    localparam int CFG_SEED_EN  = 4;

    // status bit positions
    localparam int STS_DATA  = 0;
    localparam int STS_TLAST = 1;
    localparam int STS_STRB  = 2;
    localparam int STS_OVF   = 3;

    // Programmed step register holds (step - 1), so all-zero means step 1.
    function automatic logic [63:0] yuri_step(input logic [31:0] hi, input logic [31:0] lo);
        return {hi, lo} + 64'd1;
    endfunction

endpackage

// File: rtl/axi_xdma_st_yuri_pattern_next.sv
// Purpose : next value of the counter pattern (hold / count down / count up by step).
// Latency : combinational.
// Backpressure: none; caller decides when to advance.
// Ports: i_cur current value, i_step step, i_hold/i_down mode, o_nxt next value.
module axi_xdma_st_yuri_pattern_next #(
    parameter int W = 128
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_step,
    input  logic         i_hold,
    input  logic         i_down,
    output logic [W-1:0] o_nxt
);

    always_comb begin
        o_nxt = i_cur;
        if (!i_hold) begin
            o_nxt = i_down ? (i_cur - i_step) : (i_cur + i_step);
        end
    end

endmodule

// File: rtl/axi_xdma_st_data_chk_yuri_slave_stream.sv
// Purpose : AXI-Stream sink that checks H2C data against the counter pattern, TLAST placement and TSTRB.
// Latency : all outputs registered; counters/status reflect a beat one cycle after its accept.
// Backpressure: TREADY registered, low in reset/IDLE, optionally throttled 1,1,1,0; never depends on TVALID.
// Ports: S_AXIS_* stream slave; config_reg0..2 control/step; err/beat/pkt counts, status flags, first_err_beat.
module axi_xdma_st_data_chk_yuri_slave_stream
    import axi_xdma_st_yuri_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH  = 128,
    parameter int NUMBER_OF_INPUT_WORDS = 64
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESET,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    input  logic [31:0]                         config_reg0,
    input  logic [31:0]                         config_reg1,
    input  logic [31:0]                         config_reg2,
    output logic [31:0]                         err_count,
    output logic [31:0]                         beat_count,
    output logic [31:0]                         pkt_count,
    output logic [3:0]                          status,
    output logic [31:0]                         first_err_beat
);

    localparam int         W         = C_S_AXIS_TDATA_WIDTH;
    localparam bit         TLAST_CHK = (NUMBER_OF_INPUT_WORDS != 0);
    localparam logic [31:0] LAST_IDX = TLAST_CHK ? 32'(NUMBER_OF_INPUT_WORDS - 1) : 32'd0;

    logic [1:0]   r_state;
    logic [1:0]   r_thr;
    logic         r_tready;
    logic         r_clr_prev;
    logic [W-1:0] r_exp;
    logic [31:0]  r_err;
    logic [31:0]  r_beat;
    logic [31:0]  r_pkt;
    logic [3:0]   r_sts;
    logic [31:0]  r_first;
    logic [31:0]  r_idx;

    logic [1:0]   w_state_nxt;
    logic [1:0]   w_thr_nxt;
    logic [W-1:0] w_step;
    logic [W-1:0] w_nxt_src;
    logic [W-1:0] w_exp_nxt;
    logic         w_acc;
    logic         w_clr;
    logic         w_mis;
    logic         w_idx_last;
    logic         w_strb_bad;
    logic         w_unused_cfg;

    assign w_unused_cfg = &{1'b0, config_reg0[31:5]};

    assign w_step     = W'(yuri_step(config_reg1, config_reg2));
    assign w_acc      = S_AXIS_TVALID && r_tready;
    assign w_clr      = config_reg0[CFG_CLEAR] && !r_clr_prev;
    assign w_mis      = (r_state == ST_RUN) && (S_AXIS_TDATA != r_exp);
    assign w_idx_last = (r_idx == LAST_IDX);
    assign w_strb_bad = (S_AXIS_TSTRB != '1);

    // The seed beat restarts the sequence from received data; otherwise the
    // sequence always advances from its own expected value so one corrupted
    // beat yields one error.
    assign w_nxt_src = (r_state == ST_SEED) ? S_AXIS_TDATA : r_exp;

    axi_xdma_st_yuri_pattern_next #(.W(W)) u_pattern_next (
        .i_cur  (w_nxt_src),
        .i_step (w_step),
        .i_hold (config_reg0[CFG_HOLD]),
        .i_down (config_reg0[CFG_DOWN]),
        .o_nxt  (w_exp_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = config_reg0[CFG_SEED_EN] ? ST_SEED : ST_RUN;
            ST_SEED: if (w_acc) w_state_nxt = ST_RUN;
            default: w_state_nxt = r_state;
        endcase
    end

    // Throttle phase is held at 0 through IDLE so the first ready cycle
    // starts the 1,1,1,0 pattern.
    assign w_thr_nxt = (r_state == ST_IDLE) ? 2'd0 : r_thr + 2'd1;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_state    <= ST_IDLE;
            r_thr      <= 2'd0;
            r_tready   <= 1'b0;
            r_clr_prev <= 1'b0;
            r_exp      <= W'(1);
            r_err      <= '0;
            r_beat     <= '0;
            r_pkt      <= '0;
            r_sts      <= '0;
            r_first    <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_thr      <= w_thr_nxt;
            r_tready   <= (w_state_nxt != ST_IDLE) &&
                          !(config_reg0[CFG_THROTTLE] && (w_thr_nxt == 2'd3));
            r_clr_prev <= config_reg0[CFG_CLEAR];

            if (w_acc) begin
                r_exp <= w_exp_nxt;
            end

            // Clear beats a coincident accept for every counter and flag.
            if (w_clr) begin
                r_err   <= '0;
                r_beat  <= '0;
                r_pkt   <= '0;
                r_sts   <= '0;
                r_first <= '0;
                r_idx   <= '0;
            end else if (w_acc) begin
                r_beat <= r_beat + 32'd1;
                if (S_AXIS_TLAST) begin
                    r_pkt <= r_pkt + 32'd1;
                end
                if (w_strb_bad) begin
                    r_sts[STS_STRB] <= 1'b1;
                end
                if (w_mis) begin
                    if (r_err != 32'hFFFF_FFFF) begin
                        r_err <= r_err + 32'd1;
                    end
                    if (r_err >= 32'hFFFF_FFFE) begin
                        r_sts[STS_OVF] <= 1'b1;
                    end
                    r_sts[STS_DATA] <= 1'b1;
                    if (!r_sts[STS_DATA]) begin
                        r_first <= r_beat;
                    end
                end
                if (TLAST_CHK) begin
                    if (S_AXIS_TLAST != w_idx_last) begin
                        r_sts[STS_TLAST] <= 1'b1;
                    end
                    r_idx <= (S_AXIS_TLAST || w_idx_last) ? 32'd0 : r_idx + 32'd1;
                end
            end
        end
    end

    assign S_AXIS_TREADY  = r_tready;
    assign err_count      = r_err;
    assign beat_count     = r_beat;
    assign pkt_count      = r_pkt;
    assign status         = r_sts;
    assign first_err_beat = r_first;

endmodule

// File: tb/tb_axi_xdma_st_data_chk_yuri_slave_stream.sv
// Purpose : self-checking bench for the stream pattern checker against a behavioural model.
// Latency : model counters are compared one cycle after each accept.
// Backpressure: the model predicts TREADY and the bench holds each beat until it is accepted.
module tb_axi_xdma_st_data_chk_yuri_slave_stream;

    localparam int W = 128;
    localparam int N = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           tready;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast;
    logic           tvalid;
    logic [31:0]    cfg0, cfg1, cfg2;
    logic [31:0]    err_count, beat_count, pkt_count, first_err_beat;
    logic [3:0]     status;

    always #5 clk = ~clk;

    axi_xdma_st_data_chk_yuri_slave_stream #(
        .C_S_AXIS_TDATA_WIDTH  (W),
        .NUMBER_OF_INPUT_WORDS (N)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESET  (rst),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .S_AXIS_TVALID  (tvalid),
        .config_reg0    (cfg0),
        .config_reg1    (cfg1),
        .config_reg2    (cfg2),
        .err_count      (err_count),
        .beat_count     (beat_count),
        .pkt_count      (pkt_count),
        .status         (status),
        .first_err_beat (first_err_beat)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] m_exp;
    int           m_k;          // cycles since reset release (0 = the idle cycle)
    bit           m_seed;
    logic [31:0]  m_err, m_beat, m_pkt, m_first;
    logic [3:0]   m_sts;
    int           m_idx;
    bit           m_clr_prev;

    // Stimulus state
    logic [W-1:0] g;
    int           gap_max;

    function automatic logic [W-1:0] adv(input logic [W-1:0] x);
        logic [63:0]  s64;
        logic [W-1:0] s;
        s64 = {cfg1, cfg2} + 64'd1;
        s   = W'(s64);
        if (cfg0[0]) return x;
        if (cfg0[1]) return x - s;
        return x + s;
    endfunction

    function automatic bit m_ready();
        if (m_k < 1) return 1'b0;
        if (cfg0[3] && (((m_k - 1) % 4) == 3)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare all outputs, then advance the model by what this cycle does.
    task automatic cyc();
        bit acc;
        bit pos_last;
        chk("tready", W'(tready), W'(m_ready()));
        chk("err_count", W'(err_count), W'(m_err));
        chk("beat_count", W'(beat_count), W'(m_beat));
        chk("pkt_count", W'(pkt_count), W'(m_pkt));
        chk("status", W'(status), W'(m_sts));
        chk("first_err_beat", W'(first_err_beat), W'(m_first));
        acc = tvalid && m_ready();
        @(posedge clk);
        if (m_k == 0) begin
            m_seed = cfg0[4];
        end else if (acc) begin
            if (m_seed) begin
                m_exp  = adv(tdata);
                m_seed = 1'b0;
            end else begin
                if (tdata !== m_exp) begin
                    if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
                    if (m_err == 32'hFFFF_FFFF) m_sts[3] = 1'b1;
                    if (!m_sts[0]) m_first = m_beat;
                    m_sts[0] = 1'b1;
                end
                m_exp = adv(m_exp);
            end
            if (tstrb !== '1) m_sts[2] = 1'b1;
            pos_last = (m_idx == N - 1);
            if (tlast != pos_last) m_sts[1] = 1'b1;
            m_idx  = (tlast || pos_last) ? 0 : m_idx + 1;
            m_beat = m_beat + 1;
            if (tlast) m_pkt = m_pkt + 1;
        end
        if (cfg0[2] && !m_clr_prev) begin
            m_err = 0; m_beat = 0; m_pkt = 0; m_sts = 0; m_first = 0; m_idx = 0;
        end
        m_clr_prev = cfg0[2];
        m_k++;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
        rst    = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tstrb  = '1;
        tdata  = '0;
        cfg0 = c0; cfg1 = c1; cfg2 = c2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_exp = W'(1); m_k = 0; m_seed = 1'b0;
        m_err = 0; m_beat = 0; m_pkt = 0; m_sts = 0; m_first = 0; m_idx = 0;
        m_clr_prev = 1'b0;
    endtask

    // Present one beat, holding it until the model says it was accepted.
    task automatic send(input logic [W-1:0] d, input logic last, input logic [W/8-1:0] strb);
        bit done;
        int gaps;
        gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        tvalid = 1'b0;
        for (int i = 0; i < gaps; i++) cyc();
        tvalid = 1'b1; tdata = d; tlast = last; tstrb = strb;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            done = m_ready();
            cyc();
        end
        if (!done) begin
            total++; bad++;
            $error("FAIL accept_timeout observed=not_accepted expected=accepted");
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    // n beats of the generator pattern from g; last_at/corrupt_at are 1-based (0 = none).
    task automatic stream(input int n, input int last_at, input int corrupt_at);
        logic [W-1:0] d;
        for (int i = 1; i <= n; i++) begin
            d = g;
            if (i == corrupt_at) d = W'(128'hDEAD);
            send(d, (i == last_at), '1);
            g = adv(g);
        end
    endtask

    task automatic pulse_clear();
        cfg0[2] = 1'b1; cyc();
        cfg0[2] = 1'b0; cyc();
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tstrb = '1; tdata = '0;
        cfg0 = '0; cfg1 = '0; cfg2 = '0;
        gap_max = 2;

        // 1: clean packet 1..64
        do_reset(32'h0, 32'h0, 32'h0);
        cyc();
        g = W'(1);
        stream(64, 64, 0);
        cyc();
        chk("t1_err", W'(err_count), W'(0));
        chk("t1_beat", W'(beat_count), W'(64));
        chk("t1_pkt", W'(pkt_count), W'(1));
        chk("t1_status", W'(status), W'(0));

        // 2: beat 10 corrupted
        do_reset(32'h0, 32'h0, 32'h0);
        g = W'(1);
        stream(64, 64, 10);
        cyc();
        chk("t2_err", W'(err_count), W'(1));
        chk("t2_status", W'(status), W'(1));
        chk("t2_first", W'(first_err_beat), W'(9));

        // 3: step 4 counting down through zero
        do_reset(32'h2, 32'h0, 32'h3);
        v = W'(1);                send(v, 1'b0, '1);
        v = '0; v = v - W'(3);    send(v, 1'b0, '1);
        v = '0; v = v - W'(7);    send(v, 1'b0, '1);
        cyc();
        chk("t3_err", W'(err_count), W'(0));
        chk("t3_beat", W'(beat_count), W'(3));

        // 4: early TLAST, realigned packet, clear, clean packet
        do_reset(32'h0, 32'h0, 32'h0);
        g = W'(1);
        stream(32, 32, 0);
        chk("t4_tlast_err", W'(status[1]), W'(1));
        stream(64, 64, 0);
        chk("t4_pkt", W'(pkt_count), W'(2));
        pulse_clear();
        stream(64, 64, 0);
        cyc();
        chk("t4_status_after_clear", W'(status), W'(0));
        chk("t4_pkt_after_clear", W'(pkt_count), W'(1));

        // 5: throttled TREADY with TVALID held high
        gap_max = 0;
        do_reset(32'h8, 32'h0, 32'h0);
        g = W'(1);
        stream(40, 0, 0);
        cyc();
        chk("t5_err", W'(err_count), W'(0));
        chk("t5_beat", W'(beat_count), W'(40));

        // 6: seeded start, mid-stream clear, then reset mid-packet
        gap_max = 2;
        do_reset(32'h10, 32'h0, 32'h0);
        g = W'(32'h1000);
        stream(20, 0, 0);
        cfg0[2] = 1'b1;
        stream(1, 0, 0);
        cfg0[2] = 1'b0;
        stream(20, 0, 0);
        cyc();
        chk("t6_err", W'(err_count), W'(0));
        stream(5, 0, 0);
        do_reset(32'h0, 32'h0, 32'h0);
        chk("t6_rst_tready", W'(tready), W'(0));
        chk("t6_rst_beat", W'(beat_count), W'(0));
        g = W'(1);
        stream(5, 0, 0);
        cyc();
        chk("t6_exp_from_one", W'(err_count), W'(0));

        // 7: randomized step, direction, throttle, corruption, strobe and TLAST faults
        for (int r = 0; r < 3; r++) begin
            do_reset({28'h0, 1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)), 1'b0},
                     $urandom, $urandom);
            g = W'(1);
            for (int i = 1; i <= 80; i++) begin
                logic [W/8-1:0] s;
                v = g;
                if ($urandom_range(7, 0) == 0) v = v ^ W'({$urandom, $urandom} | 64'h1);
                s = ($urandom_range(15, 0) == 0) ? 16'h7FFF : 16'hFFFF;
                send(v, ($urandom_range(19, 0) == 0) || (i % N == 0), s);
                g = adv(g);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
